// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 fetch-side PC prediction logic.
// Contents: instruction codes steering prediction, fetch state encoding, default address width.
// Imported by pc_predict_unit and pc_ras.
package y86_pkg;

  localparam int Y86_ADDR_W = 64;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    HALT     = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; push overwrites the oldest entry when full.
// Ports: clk/rst (sync, active-high), push + push_data, pop, top (combinational),
//        count (valid entries, saturating at DEPTH), ovf (sticky overwrite flag).
module pc_ras
  import y86_pkg::*;
#(
  parameter int AW    = Y86_ADDR_W,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;
  logic [PW-1:0] wr_ptr_inc;

  // wr_ptr is the next free slot; the top entry sits one below it, wrapping.
  assign top_ptr    = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
  assign wr_ptr_inc = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign top        = mem[top_ptr];

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (push) begin
      wr_ptr <= wr_ptr_inc;
      // When full, the write lands on the oldest entry, so depth stays put.
      if (count == CW'(DEPTH)) begin
        ovf <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end else if (pop && (count != '0)) begin
      wr_ptr <= top_ptr;
      count  <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC generator: predicted-PC register, redirect mux, stall/halt/ret-wait control.
// Ports: clk/rst (sync, active-high); F-stage fetch info (f_valid, f_stall, f_icode, f_valC, f_valP);
//        M/W redirects; outputs f_pc, f_bubble (combinational), halted, ras_count, ras_ovf.
// Optional macro RAS_PRED_EN: adds a return-address stack so ret is predicted without waiting.
module pc_predict_unit
  import y86_pkg::*;
#(
  parameter int              ADDR_W    = Y86_ADDR_W,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           f_valid,
  input  logic                           f_stall,
  input  logic [3:0]                     f_icode,
  input  logic [ADDR_W-1:0]              f_valC,
  input  logic [ADDR_W-1:0]              f_valP,
  input  logic                           m_redirect,
  input  logic [ADDR_W-1:0]              m_valA,
  input  logic                           w_redirect,
  input  logic [ADDR_W-1:0]              w_valM,
  output logic [ADDR_W-1:0]              f_pc,
  output logic                           f_bubble,
  output logic                           halted,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_ovf
);

  localparam int CW = $clog2(RAS_DEPTH + 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pred_q, pred_d;
  logic              redir;
  logic              advance;

`ifdef RAS_PRED_EN
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;

  pc_ras #(
    .AW    (ADDR_W),
    .DEPTH (RAS_DEPTH),
    .CW    (CW)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (f_valP),
    .top       (ras_top),
    .count     (ras_count),
    .ovf       (ras_ovf)
  );
`else
  assign ras_count = '0;
  assign ras_ovf   = 1'b0;
`endif

  assign redir  = m_redirect | w_redirect;
  assign halted = (state_q == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pred_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pred_q  <= pred_d;
    end
  end

  always_comb begin
    f_pc     = pred_q;
    f_bubble = 1'b0;
    state_d  = state_q;
    pred_d   = pred_q;
    advance  = 1'b0;
`ifdef RAS_PRED_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
`endif

    // HALT ignores everything but reset, so the mux and prediction only run when live.
    if (state_q != HALT) begin
      if (m_redirect) begin
        f_pc = m_valA;
      end else if (w_redirect) begin
        f_pc = w_valM;
      end
      f_bubble = (state_q == RET_WAIT) && !redir;
      // A redirect advances even through a stall: the corrected fetch must be predicted.
      advance  = redir || ((state_q == RUN) && f_valid && !f_stall);
    end

    if (advance) begin
      state_d = RUN;
      case (f_icode)
        I_JXX: pred_d = f_valC;
        I_CALL: begin
          pred_d = f_valC;
`ifdef RAS_PRED_EN
          ras_push = 1'b1;
`endif
        end
        I_RET: begin
`ifdef RAS_PRED_EN
          if (ras_count != '0) begin
            pred_d  = ras_top;
            ras_pop = 1'b1;
          end else begin
            state_d = RET_WAIT;
          end
`else
          state_d = RET_WAIT;
`endif
        end
        I_HALT:  state_d = HALT;
        default: pred_d = f_valP;
      endcase
    end
  end

  // The M stage cannot hold a conditional jump while fetch is parked on a ret.
  a_no_mredir_in_wait: assert property (
    @(posedge clk) disable iff (rst) !((state_q == RET_WAIT) && m_redirect)
  );

endmodule

// File: tb/tb_pc_predict_unit.sv
module tb_pc_predict_unit;

  localparam int          AW    = 64;
  localparam int          DEPTH = 2;
  localparam logic [63:0] RPC   = 64'h100;
`ifdef RAS_PRED_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, f_valid, f_stall, m_redirect, w_redirect;
  logic [3:0]    f_icode;
  logic [AW-1:0] f_valC, f_valP, m_valA, w_valM, f_pc;
  logic          f_bubble, halted, ras_ovf;
  logic [$clog2(DEPTH+1)-1:0] ras_count;

  always #5 clk = ~clk;

  pc_predict_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_stall(f_stall), .f_icode(f_icode),
    .f_valC(f_valC), .f_valP(f_valP), .m_redirect(m_redirect), .m_valA(m_valA),
    .w_redirect(w_redirect), .w_valM(w_valM), .f_pc(f_pc), .f_bubble(f_bubble),
    .halted(halted), .ras_count(ras_count), .ras_ovf(ras_ovf)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Reference model: mode 0 = running, 1 = waiting for ret target, 2 = halted.
  logic [63:0] mdl_pred;
  int          mdl_mode;
  logic [63:0] mdl_ras[$];
  bit          mdl_ovf;

  function automatic logic [63:0] exp_fpc(input bit mr, input logic [63:0] ma,
                                          input bit wr, input logic [63:0] wm);
    if (mdl_mode == 2) return mdl_pred;
    if (mr) return ma;
    if (wr) return wm;
    return mdl_pred;
  endfunction

  task automatic idle_inputs();
    rst = 0; f_valid = 0; f_stall = 0; f_icode = 4'h1; f_valC = '0; f_valP = '0;
    m_redirect = 0; m_valA = '0; w_redirect = 0; w_valM = '0;
  endtask

  // One clock: drive, check outputs against the model, clock, update model, go idle.
  task automatic cyc(input bit r, input bit fv, input bit fs, input logic [3:0] ic,
                     input logic [63:0] vc, input logic [63:0] vp,
                     input bit mr, input logic [63:0] ma, input bit wr, input logic [63:0] wm);
    logic [63:0] pc;
    bit adv;
    @(negedge clk);
    rst = r; f_valid = fv; f_stall = fs; f_icode = ic; f_valC = vc; f_valP = vp;
    m_redirect = mr; m_valA = ma; w_redirect = wr; w_valM = wm;
    #1;
    pc = exp_fpc(mr, ma, wr, wm);
    chk("f_pc", f_pc, pc);
    chk("f_bubble", 64'(f_bubble), 64'(mdl_mode == 1 && !(mr || wr)));
    chk("halted", 64'(halted), 64'(mdl_mode == 2));
    chk("ras_count", 64'(ras_count), 64'(mdl_ras.size()));
    chk("ras_ovf", 64'(ras_ovf), 64'(mdl_ovf));
    @(posedge clk);
    if (r) begin
      mdl_pred = RPC; mdl_mode = 0; mdl_ras.delete(); mdl_ovf = 0;
    end else if (mdl_mode != 2) begin
      adv = mr || wr || (mdl_mode == 0 && fv && !fs);
      if (adv) begin
        mdl_mode = 0;
        if (ic == 4'd7) mdl_pred = vc;
        else if (ic == 4'd8) begin
          mdl_pred = vc;
          if (RAS_ON) begin
            mdl_ras.push_back(vp);
            if (mdl_ras.size() > DEPTH) begin
              void'(mdl_ras.pop_front());
              mdl_ovf = 1;
            end
          end
        end else if (ic == 4'd9) begin
          if (RAS_ON && mdl_ras.size() > 0) mdl_pred = mdl_ras.pop_back();
          else mdl_mode = 1;
        end else if (ic == 4'd0) mdl_mode = 2;
        else mdl_pred = vp;
      end
    end
    #1;
    idle_inputs();
    #1;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
    cyc(0, 1, 0, ic, vc, vp, 0, '0, 0, '0);
  endtask

  task automatic wfix(input logic [63:0] wm, input logic [3:0] ic, input logic [63:0] vp);
    cyc(0, 1, 0, ic, '0, vp, 0, '0, 1, wm);
  endtask

  initial begin
    logic [63:0] r64a, r64b;
    idle_inputs();
    rst = 1;
    @(posedge clk);
    mdl_pred = RPC; mdl_mode = 0; mdl_ovf = 0;
    #1; rst = 0; #1;

    // Reset state
    chk("rst_fpc", f_pc, 64'h100);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_rascnt", 64'(ras_count), 64'd0);
    chk("rst_bubble", 64'(f_bubble), 64'd0);

    // Jump predicted taken, then M-stage mispredict redirect in the same cycle
    fetch(4'h1, '0, 64'h10);
    fetch(4'h7, 64'h40, 64'h19);
    chk("jxx_pred", f_pc, 64'h40);
    cyc(0, 1, 0, 4'h1, '0, 64'h1b, 1, 64'h19, 0, '0);
    chk("mredir_next", f_pc, 64'h1b);

    // Call/ret pair
    fetch(4'h1, '0, 64'h20);
    fetch(4'h8, 64'h80, 64'h29);
    chk("call_pc", f_pc, 64'h80);
    chk("call_cnt", 64'(ras_count), RAS_ON ? 64'd1 : 64'd0);
    fetch(4'h9, '0, 64'h82);
    chk("ret_pc", f_pc, RAS_ON ? 64'h29 : 64'h80);
    chk("ret_bubble", 64'(f_bubble), RAS_ON ? 64'd0 : 64'd1);
    chk("ret_cnt", 64'(ras_count), 64'd0);

    // Ret with empty stack waits for the W-stage target
    wfix(64'h30, 4'h1, 64'h31);
    fetch(4'h9, '0, 64'h32);
    chk("wait_bubble", 64'(f_bubble), 64'd1);
    chk("wait_pc", f_pc, 64'h31);
    for (int i = 0; i < 3; i++) fetch(4'h1, '0, 64'h99);
    chk("wait_hold", f_pc, 64'h31);
    wfix(64'h55, 4'h1, 64'h59);
    chk("wait_exit", f_pc, 64'h59);
    chk("wait_exit_bub", 64'(f_bubble), 64'd0);

    // Overflow: three calls into a depth-2 stack
    fetch(4'h8, 64'h200, 64'h1);
    fetch(4'h8, 64'h300, 64'h2);
    fetch(4'h8, 64'h400, 64'h3);
    chk("ovf_cnt", 64'(ras_count), RAS_ON ? 64'd2 : 64'd0);
    chk("ovf_flag", 64'(ras_ovf), RAS_ON ? 64'd1 : 64'd0);
    fetch(4'h9, '0, 64'h0);
    chk("ovf_ret1", f_pc, RAS_ON ? 64'h3 : 64'h400);
    if (RAS_ON) begin
      fetch(4'h9, '0, 64'h0);
      chk("ovf_ret2", f_pc, 64'h2);
      fetch(4'h9, '0, 64'h0);
    end
    chk("ovf_ret3_bub", 64'(f_bubble), 64'd1);
    wfix(64'h70, 4'h1, 64'h74);

    // Halt under stall is ignored; once fetched, everything is frozen until reset
    cyc(0, 1, 1, 4'h0, '0, 64'h75, 0, '0, 0, '0);
    chk("halt_stalled", 64'(halted), 64'd0);
    fetch(4'h0, '0, 64'h75);
    chk("halt_set", 64'(halted), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 4'h7, 64'hdead, 64'hbeef, i[0], 64'h111, i[1], 64'h222);
      chk("halt_frozen", f_pc, 64'h74);
    end
    cyc(1, 0, 0, 4'h1, '0, '0, 0, '0, 0, '0);
    chk("halt_rst_pc", f_pc, 64'h100);
    chk("halt_rst_h", 64'(halted), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] ic;
      bit r, mr, wr;
      ic = 4'($urandom_range(1, 11));
      if ($urandom_range(0, 60) == 0) ic = 4'h0;
      r  = ($urandom_range(0, 250) == 0) || (mdl_mode == 2 && $urandom_range(0, 6) == 0);
      mr = (mdl_mode == 0) && ($urandom_range(0, 9) == 0);
      wr = (mdl_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 14) == 0);
      r64a = {$urandom, $urandom};
      r64b = {$urandom, $urandom};
      cyc(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, ic,
          r64a, r64b, mr, {$urandom, $urandom}, wr, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
